fetch_controller: RTL and testbench

Instruction-fetch sequencer for the 10-bit pipelined CPU. It owns the program counter and drives the address port of InstructionMemory, which is a synchronous-read memory with a 1-cycle read latency. It delivers an ordered stream of (pc, instruction, valid) to the decode stage, and handles decode stalls, branch/jump redirects and HALT. A 2-entry skid buffer ensures that no instruction fetched during a stall is lost or duplicated.

---
 rtl/fetch_controller.sv | 139 +++++++++++++
 tb/tb_fetch_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle synchronous-read
// instruction memory and streams (pc, instruction, valid) to decode through a 2-entry skid.
module fetch_controller #(
  parameter int                         ADDR_WIDTH = 10,
  parameter int                         DATA_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] im_address,
  input  logic [DATA_WIDTH-1:0] im_instruction,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  halt,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  halted
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          im_address_q, im_address_d;
  logic [ADDR_WIDTH-1:0]          pc_q, pc_d;
  logic                           issue_valid_q, issue_valid_d;
  logic                           resp_valid_q, resp_valid_d;
  logic [ADDR_WIDTH-1:0]          resp_pc_q, resp_pc_d;
  logic [1:0][DATA_WIDTH-1:0]     skid_instr_q, skid_instr_d;
  logic [1:0][ADDR_WIDTH-1:0]     skid_pc_q, skid_pc_d;
  logic [1:0]                     skid_cnt_q, skid_cnt_d;
  logic                           if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0]          if_instruction_q, if_instruction_d;
  logic [ADDR_WIDTH-1:0]          if_pc_q, if_pc_d;

  always_comb begin
    state_d          = state_q;
    im_address_d     = im_address_q;
    pc_d             = pc_q;
    issue_valid_d    = issue_valid_q;
    // The issued address always becomes the word on im_instruction next cycle.
    resp_valid_d     = issue_valid_q;
    resp_pc_d        = im_address_q;
    skid_instr_d     = skid_instr_q;
    skid_pc_d        = skid_pc_q;
    skid_cnt_d       = skid_cnt_q;
    if_valid_d       = if_valid_q;
    if_instruction_d = if_instruction_q;
    if_pc_d          = if_pc_q;

    if (state_q == HALTED) begin
      issue_valid_d = 1'b0;
      resp_valid_d  = 1'b0;
    end else if (redirect_valid) begin
      im_address_d  = redirect_target;
      pc_d          = redirect_target + 1'b1;
      issue_valid_d = 1'b1;
      resp_valid_d  = 1'b0;
      skid_cnt_d    = 2'd0;
      if_valid_d    = 1'b0;
    end else if (halt) begin
      issue_valid_d = 1'b0;
      resp_valid_d  = 1'b0;
      skid_cnt_d    = 2'd0;
      if_valid_d    = 1'b0;
      state_d       = HALTED;
    end else begin
      if (!stall) begin
        im_address_d  = pc_q;
        pc_d          = pc_q + 1'b1;
        issue_valid_d = 1'b1;
        if (skid_cnt_q != 2'd0) begin
          if_valid_d       = 1'b1;
          if_instruction_d = skid_instr_q[0];
          if_pc_d          = skid_pc_q[0];
          skid_instr_d[0]  = skid_instr_q[1];
          skid_pc_d[0]     = skid_pc_q[1];
          skid_cnt_d       = skid_cnt_q - 2'd1;
        end else begin
          if_valid_d       = resp_valid_q;
          if_instruction_d = im_instruction;
          if_pc_d          = resp_pc_q;
        end
      end else begin
        issue_valid_d = 1'b0;
      end
      // A live response goes to the skid whenever it cannot go straight to decode.
      if (resp_valid_q && (stall || skid_cnt_q != 2'd0)) begin
        if (skid_cnt_d == 2'd0) begin
          skid_instr_d[0] = im_instruction;
          skid_pc_d[0]    = resp_pc_q;
          skid_cnt_d      = 2'd1;
        end else begin
          skid_instr_d[1] = im_instruction;
          skid_pc_d[1]    = resp_pc_q;
          skid_cnt_d      = skid_cnt_d + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= RUN;
      im_address_q     <= RESET_PC;
      pc_q             <= RESET_PC + 1'b1;
      issue_valid_q    <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_pc_q        <= '0;
      skid_instr_q     <= '0;
      skid_pc_q        <= '0;
      skid_cnt_q       <= 2'd0;
      if_valid_q       <= 1'b0;
      if_instruction_q <= '0;
      if_pc_q          <= '0;
    end else begin
      state_q          <= state_d;
      im_address_q     <= im_address_d;
      pc_q             <= pc_d;
      issue_valid_q    <= issue_valid_d;
      resp_valid_q     <= resp_valid_d;
      resp_pc_q        <= resp_pc_d;
      skid_instr_q     <= skid_instr_d;
      skid_pc_q        <= skid_pc_d;
      skid_cnt_q       <= skid_cnt_d;
      if_valid_q       <= if_valid_d;
      if_instruction_q <= if_instruction_d;
      if_pc_q          <= if_pc_d;
    end
  end

  assign im_address     = im_address_q;
  assign if_valid       = if_valid_q;
  assign if_instruction = if_instruction_q;
  assign if_pc          = if_pc_q;
  assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: free-run, stall/skid, redirects, halt, reset mid-stall.
module tb_fetch_controller;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [9:0] im_address;
  logic [9:0] im_instruction = '0;
  logic       stall, redirect_valid, halt;
  logic [9:0] redirect_target;
  logic       if_valid, halted;
  logic [9:0] if_instruction, if_pc;
  int total = 0;
  int bad   = 0;

  fetch_controller dut (
    .clock(clock), .reset_n(reset_n), .im_address(im_address),
    .im_instruction(im_instruction), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .if_valid(if_valid), .if_instruction(if_instruction),
    .if_pc(if_pc), .halted(halted)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory, word[a] = a ^ 10'h155.
  always @(posedge clock) im_instruction <= im_address ^ 10'h155;

  always @(negedge clock)
    if (reset_n) assert (dut.skid_cnt_q <= 2'd2) else $error("skid overflow");

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reset, release, and run until if_pc == n is on the outputs.
  task automatic restart(input int n);
    stall = 0; redirect_valid = 0; halt = 0; redirect_target = '0;
    reset_n = 0;
    step();
    reset_n = 1;
    step(); step();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    stall = 0; redirect_valid = 0; halt = 0; redirect_target = '0;
    reset_n = 0;
    #1;
    total++;
    if ({if_valid, if_pc, if_instruction, halted, im_address} !== 32'h0) begin
      bad++;
      $display("FAIL reset_values got v=%0b pc=%h ins=%h h=%0b ia=%h want all 0",
               if_valid, if_pc, if_instruction, halted, im_address);
    end
    @(negedge clock);
    reset_n = 1;
    step();
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL first_edge_valid got %0b want 0", if_valid);
    end
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 10'h000 || if_instruction !== 10'h155) begin
      bad++;
      $display("FAIL first_fetch got v=%0b pc=%h ins=%h want 1/000/155", if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_free_run();
    logic [9:0] e;
    for (int i = 1; i <= 3; i++) begin
      step();
      e = 10'(i);
      total++;
      if (if_valid !== 1'b1 || if_pc !== e || if_instruction !== (e ^ 10'h155)) begin
        bad++;
        $display("FAIL free_run got v=%0b pc=%h ins=%h want pc=%h", if_valid, if_pc, if_instruction, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [9:0] e;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 10'h004 || if_instruction !== 10'h151) begin
        bad++;
        $display("FAIL stall_hold got v=%0b pc=%h ins=%h want pc=004 ins=151", if_valid, if_pc, if_instruction);
      end
    end
    stall = 0;
    for (int k = 5; k <= 8; k++) begin
      step();
      e = 10'(k);
      total++;
      if (if_valid !== 1'b1 || if_pc !== e || if_instruction !== (e ^ 10'h155)) begin
        bad++;
        $display("FAIL stall_release got v=%0b pc=%h ins=%h want pc=%h", if_valid, if_pc, if_instruction, e);
      end
    end
  endtask

  task automatic test_redirect();
    restart(7);
    redirect_valid = 1; redirect_target = 10'h200;
    step();
    redirect_valid = 0;
    total++;
    if (if_valid !== 1'b0 || im_address !== 10'h200) begin
      bad++; $display("FAIL redirect_flush got v=%0b ia=%h want 0/200", if_valid, im_address);
    end
    step();
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_bubble got v=%0b want 0", if_valid);
    end
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 10'h200 || if_instruction !== 10'h355) begin
      bad++; $display("FAIL redirect_target got v=%0b pc=%h ins=%h want 1/200/355", if_valid, if_pc, if_instruction);
    end
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 10'h201 || if_instruction !== 10'h354) begin
      bad++; $display("FAIL redirect_next got v=%0b pc=%h ins=%h want 1/201/354", if_valid, if_pc, if_instruction);
    end
  endtask

  task automatic test_redirect_in_stall();
    logic [9:0] exp_pc [3];
    exp_pc[0] = 10'h3FF; exp_pc[1] = 10'h000; exp_pc[2] = 10'h001;
    restart(3);
    stall = 1;
    step(); step();
    redirect_valid = 1; redirect_target = 10'h3FF;
    step();
    redirect_valid = 0; stall = 0;
    total++;
    if (if_valid !== 1'b0 || im_address !== 10'h3FF) begin
      bad++; $display("FAIL stall_redirect_flush got v=%0b ia=%h want 0/3ff", if_valid, im_address);
    end
    step();
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL stall_redirect_bubble got v=%0b want 0", if_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[i] || if_instruction !== (exp_pc[i] ^ 10'h155)) begin
        bad++;
        $display("FAIL wrap_stream got v=%0b pc=%h ins=%h want pc=%h", if_valid, if_pc, if_instruction, exp_pc[i]);
      end
    end
  endtask

  task automatic test_halt();
    restart(2);
    halt = 1; redirect_valid = 1; redirect_target = 10'h050;
    step();
    halt = 0; redirect_valid = 0;
    total++;
    if (halted !== 1'b0 || im_address !== 10'h050) begin
      bad++; $display("FAIL redirect_beats_halt got h=%0b ia=%h want 0/050", halted, im_address);
    end
    step(); step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 10'h050) begin
      bad++; $display("FAIL post_redirect got v=%0b pc=%h want 1/050", if_valid, if_pc);
    end
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 10'h051) begin
      bad++; $display("FAIL post_redirect_next got v=%0b pc=%h want 1/051", if_valid, if_pc);
    end
    halt = 1;
    step();
    halt = 0;
    // Inputs after halt must be ignored.
    redirect_valid = 1; redirect_target = 10'h123; stall = 1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (halted !== 1'b1 || if_valid !== 1'b0 || im_address !== 10'h053) begin
        bad++;
        $display("FAIL halted_hold got h=%0b v=%0b ia=%h want 1/0/053", halted, if_valid, im_address);
      end
      step();
    end
    redirect_valid = 0; stall = 0;
  endtask

  task automatic test_reset_mid_stall();
    restart(4);
    stall = 1;
    step(); step();
    reset_n = 0;
    #1;
    total++;
    if ({if_valid, if_pc, if_instruction, halted, im_address} !== 32'h0) begin
      bad++;
      $display("FAIL midstall_reset got v=%0b pc=%h ins=%h h=%0b ia=%h want all 0",
               if_valid, if_pc, if_instruction, halted, im_address);
    end
    stall = 0;
    @(negedge clock);
    reset_n = 1;
    step();
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL midstall_restart_bubble got v=%0b want 0", if_valid);
    end
    for (int k = 0; k <= 2; k++) begin
      step();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 10'(k)) begin
        bad++; $display("FAIL midstall_restart got v=%0b pc=%h want 1/%h", if_valid, if_pc, 10'(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_in_stall();
    test_halt();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
